// File: rtl/bk_seq_pkg.sv
// Shared types and constants for the sequential multi-word Brent-Kung add/sub scheduler.
package bk_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int unsigned WORD_W    = 16;
  localparam int unsigned ID_W      = 2;
  localparam int unsigned MAX_WORDS = 8;
  localparam int unsigned IDX_W     = 3;

endpackage

// File: rtl/bk_seq_arb_if.sv
// Requester/response bundle for bk_seq_arb; req_sub exists only when BK_SEQ_SUB_EN is defined.
interface bk_seq_arb_if
  import bk_seq_pkg::*;
#(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned WORDS = 4
);
  localparam int unsigned W = WORD_W * WORDS;

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_cin;
`ifdef BK_SEQ_SUB_EN
  logic [NREQ-1:0]   req_sub;
`endif
  logic              rsp_valid;
  logic              rsp_ready;
  logic [ID_W-1:0]   rsp_id;
  logic [W-1:0]      rsp_sum;
  logic              rsp_cout;
  logic              busy;

  modport master (
    output req_valid, req_a, req_b, req_cin, rsp_ready,
`ifdef BK_SEQ_SUB_EN
    output req_sub,
`endif
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, req_cin, rsp_ready,
`ifdef BK_SEQ_SUB_EN
    input  req_sub,
`endif
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
  );

endinterface

// File: rtl/bk_seq_arb_bk_16.sv
// 16-bit Brent-Kung parallel-prefix adder with carry in/out (purely combinational).
module bk_16 (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        ci_i,
  output logic [15:0] sum_c_o,
  output logic        cout_c_o
);

  logic [15:0] hs;
  logic [15:0] gg;
  logic [15:0] pp;

  always_comb begin
    hs    = a_i ^ b_i;
    gg    = a_i & b_i;
    pp    = hs;
    // fold carry-in into bit 0 so every prefix G includes it
    gg[0] = gg[0] | (pp[0] & ci_i);
    for (int lvl = 0; lvl < 4; lvl++) begin
      for (int i = (2 << lvl) - 1; i < 16; i += (2 << lvl)) begin
        gg[i] = gg[i] | (pp[i] & gg[i - (1 << lvl)]);
        pp[i] = pp[i] & pp[i - (1 << lvl)];
      end
    end
    for (int lvl = 2; lvl >= 0; lvl--) begin
      for (int i = 3 * (1 << lvl) - 1; i < 16; i += (2 << lvl)) begin
        gg[i] = gg[i] | (pp[i] & gg[i - (1 << lvl)]);
        pp[i] = pp[i] & pp[i - (1 << lvl)];
      end
    end
    sum_c_o  = hs ^ {gg[14:0], ci_i};
    cout_c_o = gg[15];
  end

endmodule

// File: rtl/bk_seq_arb_rr_arb.sv
// Combinational round-robin arbiter: first valid requester at or after ptr_i wins.
module rr_arb
  import bk_seq_pkg::*;
#(
  parameter int unsigned NREQ = 2
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic [NREQ-1:0] gnt_c_o,
  output logic [ID_W-1:0] gnt_id_c_o
);

  logic        found;
  int unsigned cand;

  always_comb begin
    gnt_c_o    = '0;
    gnt_id_c_o = '0;
    found      = 1'b0;
    cand       = 0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      cand = (32'(ptr_i) + off) % NREQ;
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!found && (i == cand) && valid_i[i]) begin
          found      = 1'b1;
          gnt_c_o[i] = 1'b1;
          gnt_id_c_o = ID_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/bk_seq_arb.sv
// Round-robin multi-word add/sub scheduler sharing one bk_16 across NREQ requesters.
// Optional subtract mode enabled by defining BK_SEQ_SUB_EN.
module bk_seq_arb
  import bk_seq_pkg::*;
#(
  parameter int unsigned WORDS = 4,
  parameter int unsigned NREQ  = 2
) (
  input logic         clk,
  input logic         rst,
  bk_seq_arb_if.slave bus
);

  localparam int unsigned W = WORD_W * WORDS;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              carry_q, carry_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [W-1:0]      a_q, a_d;
  logic [W-1:0]      b_q, b_d;
  logic [W-1:0]      sum_q, sum_d;
  logic              rsp_valid_q;
  logic              busy_q;
`ifdef BK_SEQ_SUB_EN
  logic              sub_q, sub_d;
  logic              sub_sel;
`endif

  logic [NREQ-1:0]   gnt;
  logic [ID_W-1:0]   gnt_id;
  logic              accept;
  logic [W-1:0]      a_sel;
  logic [W-1:0]      b_sel;
  logic              cin_sel;
  logic [WORD_W-1:0] add_a;
  logic [WORD_W-1:0] b_word;
  logic [WORD_W-1:0] add_b;
  logic [WORD_W-1:0] add_s;
  logic              add_co;

  rr_arb #(.NREQ(NREQ)) u_arb (
    .valid_i    (bus.req_valid),
    .ptr_i      (ptr_q),
    .gnt_c_o    (gnt),
    .gnt_id_c_o (gnt_id)
  );

  assign bus.req_ready = ((state_q == IDLE) && !rst) ? gnt : '0;
  assign accept        = |bus.req_ready;

  // one-hot mux of the winning requester's operands
  always_comb begin
    a_sel   = '0;
    b_sel   = '0;
    cin_sel = 1'b0;
`ifdef BK_SEQ_SUB_EN
    sub_sel = 1'b0;
`endif
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (bus.req_ready[i]) begin
        a_sel   = bus.req_a[i*W +: W];
        b_sel   = bus.req_b[i*W +: W];
        cin_sel = bus.req_cin[i];
`ifdef BK_SEQ_SUB_EN
        sub_sel = bus.req_sub[i];
`endif
      end
    end
  end

  // current word slice feeding the shared adder
  always_comb begin
    add_a  = '0;
    b_word = '0;
    for (int unsigned w = 0; w < WORDS; w++) begin
      if (idx_q == IDX_W'(w)) begin
        add_a  = a_q[w*WORD_W +: WORD_W];
        b_word = b_q[w*WORD_W +: WORD_W];
      end
    end
`ifdef BK_SEQ_SUB_EN
    add_b = b_word ^ {WORD_W{sub_q}};
`else
    add_b = b_word;
`endif
  end

  bk_16 u_add (
    .a_i      (add_a),
    .b_i      (add_b),
    .ci_i     (carry_q),
    .sum_c_o  (add_s),
    .cout_c_o (add_co)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
`ifdef BK_SEQ_SUB_EN
    sub_d   = sub_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d     = a_sel;
          b_d     = b_sel;
          id_d    = gnt_id;
          idx_d   = '0;
`ifdef BK_SEQ_SUB_EN
          sub_d   = sub_sel;
          carry_d = sub_sel | cin_sel;
`else
          carry_d = cin_sel;
`endif
          ptr_d   = (gnt_id == ID_W'(NREQ - 1)) ? '0 : gnt_id + ID_W'(1);
          state_d = ADD;
        end
      end
      ADD: begin
        for (int unsigned w = 0; w < WORDS; w++) begin
          if (idx_q == IDX_W'(w)) begin
            sum_d[w*WORD_W +: WORD_W] = add_s;
          end
        end
        carry_d = add_co;
        if (idx_q == IDX_W'(WORDS - 1)) begin
          state_d = RESP;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      ptr_q       <= '0;
      id_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef BK_SEQ_SUB_EN
      sub_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      rsp_valid_q <= (state_d == RESP);
      busy_q      <= (state_d != IDLE);
`ifdef BK_SEQ_SUB_EN
      sub_q       <= sub_d;
`endif
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_sum   = sum_q;
  assign bus.rsp_cout  = carry_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_bk_seq_arb.sv
// Directed self-checking bench for bk_seq_arb (WORDS=4, NREQ=2); subtract steps run when BK_SEQ_SUB_EN is defined.
module tb_bk_seq_arb;
  import bk_seq_pkg::*;

  localparam int unsigned WORDS = 4;
  localparam int unsigned NREQ  = 2;
  localparam int unsigned W     = WORD_W * WORDS;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  bk_seq_arb_if #(.NREQ(NREQ), .WORDS(WORDS)) bus ();

  bk_seq_arb #(.WORDS(WORDS), .NREQ(NREQ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int r, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    bus.req_a[r*W +: W] = a;
    bus.req_b[r*W +: W] = b;
    bus.req_cin[r]      = cin;
  endtask

  initial begin
    rst           = 1'b1;
    bus.req_valid = '1;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_cin   = '0;
    bus.rsp_ready = 1'b0;
`ifdef BK_SEQ_SUB_EN
    bus.req_sub   = '0;
`endif
    tick();
    tick();
    chk("rst_req_ready", W'(bus.req_ready), W'(0));
    chk("rst_rsp_valid", W'(bus.rsp_valid), W'(0));
    chk("rst_busy",      W'(bus.busy), W'(0));
    chk("rst_rsp_id",    W'(bus.rsp_id), W'(0));
    chk("rst_rsp_sum",   bus.rsp_sum, W'(0));
    chk("rst_rsp_cout",  W'(bus.rsp_cout), W'(0));
    rst           = 1'b0;
    bus.req_valid = '0;

    // word carry on requester 0, response held off for backpressure
    set_op(0, 64'h0000_0000_0000_FFFF, 64'h1, 1'b0);
    bus.req_valid = 2'b01;
    #1;
    chk("wc_grant", W'(bus.req_ready), W'(2'b01));
    tick();
    bus.req_valid = '0;
    chk("wc_busy", W'(bus.busy), W'(1));
    repeat (3) begin
      tick();
      chk("wc_no_rsp_yet", W'(bus.rsp_valid), W'(0));
    end
    tick();
    chk("wc_rsp_valid", W'(bus.rsp_valid), W'(1));
    chk("wc_rsp_sum",   bus.rsp_sum, 64'h0000_0000_0001_0000);
    chk("wc_rsp_cout",  W'(bus.rsp_cout), W'(0));
    chk("wc_rsp_id",    W'(bus.rsp_id), W'(0));

    bus.req_valid = 2'b11;
    repeat (5) begin
      tick();
      chk("bp_rsp_valid", W'(bus.rsp_valid), W'(1));
      chk("bp_rsp_sum",   bus.rsp_sum, 64'h0000_0000_0001_0000);
      chk("bp_req_ready", W'(bus.req_ready), W'(0));
      chk("bp_busy",      W'(bus.busy), W'(1));
    end
    bus.rsp_ready = 1'b1;
    tick();
    chk("bp_done_valid", W'(bus.rsp_valid), W'(0));
    chk("bp_done_busy",  W'(bus.busy), W'(0));
    chk("bp_next_grant", W'(bus.req_ready), W'(2'b10));
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;

    // full carry chain on requester 1
    set_op(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
    bus.req_valid = 2'b10;
    #1;
    chk("fc_grant", W'(bus.req_ready), W'(2'b10));
    tick();
    bus.req_valid = '0;
    repeat (4) tick();
    chk("fc_rsp_valid", W'(bus.rsp_valid), W'(1));
    chk("fc_rsp_sum",   bus.rsp_sum, W'(0));
    chk("fc_rsp_cout",  W'(bus.rsp_cout), W'(1));
    chk("fc_rsp_id",    W'(bus.rsp_id), W'(1));
    bus.rsp_ready = 1'b1;
    tick();
    chk("fc_done_valid", W'(bus.rsp_valid), W'(0));

    // both requesters valid continuously: grants alternate, period 6
    set_op(0, 64'h1, 64'h2, 1'b0);
    set_op(1, 64'h10, 64'h20, 1'b1);
    bus.req_valid = 2'b11;
    for (int n = 0; n < 4; n++) begin
      #1;
      chk("arb_grant", W'(bus.req_ready), (n % 2 == 1) ? W'(2'b10) : W'(2'b01));
      tick();
      repeat (3) tick();
      chk("arb_no_rsp_yet", W'(bus.rsp_valid), W'(0));
      tick();
      chk("arb_rsp_valid", W'(bus.rsp_valid), W'(1));
      chk("arb_rsp_id",    W'(bus.rsp_id), (n % 2 == 1) ? W'(1) : W'(0));
      chk("arb_rsp_sum",   bus.rsp_sum, (n % 2 == 1) ? W'(64'h31) : W'(64'h3));
      tick();
      chk("arb_idle", W'(bus.busy), W'(0));
    end
    bus.req_valid = '0;

`ifdef BK_SEQ_SUB_EN
    // subtraction: 5 - 7 borrows, 7 - 5 does not
    set_op(0, 64'h5, 64'h7, 1'b0);
    bus.req_sub   = 2'b01;
    bus.req_valid = 2'b01;
    #1;
    chk("sub0_grant", W'(bus.req_ready), W'(2'b01));
    tick();
    bus.req_valid = '0;
    repeat (4) tick();
    chk("sub0_rsp_sum",  bus.rsp_sum, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("sub0_rsp_cout", W'(bus.rsp_cout), W'(0));
    tick();
    set_op(1, 64'h7, 64'h5, 1'b0);
    bus.req_sub   = 2'b10;
    bus.req_valid = 2'b10;
    #1;
    chk("sub1_grant", W'(bus.req_ready), W'(2'b10));
    tick();
    bus.req_valid = '0;
    repeat (4) tick();
    chk("sub1_rsp_sum",  bus.rsp_sum, W'(64'h2));
    chk("sub1_rsp_cout", W'(bus.rsp_cout), W'(1));
    tick();
    bus.req_sub = '0;
`endif

    // reset during the second ADD cycle
    set_op(0, 64'h1, 64'h1, 1'b0);
    bus.req_valid = 2'b01;
    #1;
    chk("rm_grant", W'(bus.req_ready), W'(2'b01));
    tick();
    bus.req_valid = '0;
    tick();
    rst = 1'b1;
    tick();
    chk("rm_rsp_valid", W'(bus.rsp_valid), W'(0));
    chk("rm_busy",      W'(bus.busy), W'(0));
    chk("rm_rsp_sum",   bus.rsp_sum, W'(0));
    chk("rm_rsp_id",    W'(bus.rsp_id), W'(0));
    chk("rm_rsp_cout",  W'(bus.rsp_cout), W'(0));
    chk("rm_req_ready", W'(bus.req_ready), W'(0));
    rst = 1'b0;
    repeat (6) begin
      tick();
      chk("rm_no_rsp", W'(bus.rsp_valid), W'(0));
    end
    bus.req_valid = 2'b11;
    #1;
    chk("rm_ptr_reset", W'(bus.req_ready), W'(2'b01));
    bus.req_valid = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bk_seq_arb.md
# bk_seq_arb

Multi-word add/subtract scheduler that shares one combinational 16-bit Brent-Kung adder (`bk_16`) between up to four requesters. It arbitrates round-robin, then sequences the adder over the operand words from LSW to MSW, chaining the carry through a register. It completes each wide addition in WORDS cycles and returns the sum with its requester ID. It sits between the Dadda partial-product reduction users and the final carry-propagate stage.

## Interface
- `WORDS`, default 4: 16-bit words per operand; operand width W = 16*WORDS; legal range 1–8.
- `NREQ`, default 2: number of requesters; legal range 2–4.
- `clk` in 1: sole clock; all state changes on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in NREQ: request present, one bit per requester.
- `req_ready` out NREQ: one-hot grant; a request is accepted on an edge where its valid and ready are both high.
- `req_a` in NREQ*W: operand A per requester; requester i occupies bits [i*W +: W].
- `req_b` in NREQ*W: operand B, packed the same way.
- `req_cin` in NREQ: carry-in per requester.
- `req_sub` in NREQ: subtract select; present only with BK_SEQ_SUB_EN.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: consumer accepts the result.
- `rsp_id` out 2: index of the requester that owns the result.
- `rsp_sum` out W: result, modulo 2^W.
- `rsp_cout` out 1: carry out of the MSW.
- `busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, ADD, RESP.
- IDLE:
  - `req_ready` is combinational and goes to the round-robin winner among the valid requesters.
  - On accept: latch A, B, cin (and sub) plus the winner ID; set word index to 0; set the carry register to cin; move the priority pointer to winner+1 (mod NREQ); go to ADD.
  - With no valid request, stay in IDLE.
- ADD, one word per cycle:
  - Adder inputs: A word[idx], B word[idx], carry_in = carry register.
  - Each edge writes adder result[15:0] into the sum word[idx] and loads result[16] into the carry register.
  - When idx = WORDS-1, go to RESP; otherwise increment idx.
- RESP:
  - `rsp_valid` = 1; `rsp_sum`, `rsp_cout` and `rsp_id` are held stable.
  - On `rsp_valid && rsp_ready`, return to IDLE.
- `req_ready` is 0 in ADD and RESP. Requesters must not make `req_valid` depend on `req_ready`.
- Priority pointer: after reset, requester 0 has highest priority. Requesters with index ≥ NREQ do not exist.
- `rsp_cout` equals the final carry register value, i.e. the carry out of bit W-1.

## Timing
- Accept edge k → ADD spans cycles k..k+WORDS-1 → `rsp_valid` rises after edge k+WORDS.
- The earliest next accept is the edge after the response handshake, so the minimum period is WORDS+2 cycles.
- `req_ready` has a combinational path from `req_valid`. All other outputs are registered.
- Reset values: `req_ready` 0, `rsp_valid` 0, `rsp_id` 0, `rsp_sum` 0, `rsp_cout` 0, `busy` 0; state IDLE, idx 0, carry 0, pointer 0.
- Reset in any state aborts the operation with no response emitted. The latched operands are discarded.
- Holding `rsp_ready` low stalls indefinitely; every output stays stable and no request is accepted.

## Configuration
- `BK_SEQ_SUB_EN` defined:
  - The `req_sub` port exists.
  - When the latched sub bit is 1, B words are bit-inverted into the adder and the carry register is initialised to 1 (`req_cin` is ignored).
  - Result is A − B mod 2^W; `rsp_cout` = 1 means no borrow (A ≥ B).
- `BK_SEQ_SUB_EN` undefined: there is no `req_sub` port and the block performs addition only.

## Structure
- Package `bk_seq_pkg`: state enum {IDLE, ADD, RESP}, `WORD_W` = 16, `ID_W` = 2, `MAX_WORDS` = 8.
- Sub-module `rr_arb`: combinational round-robin grant from (valid, pointer); NREQ ≤ 4.
- The block instantiates exactly one `bk_16` as the shared adder.

## Test plan
- Word carry (WORDS=4, req0): A=0x0000_0000_0000_FFFF, B=1, cin=0 → `rsp_sum`=0x0000_0000_0001_0000, `rsp_cout`=0, `rsp_id`=0, `rsp_valid` rises 4 edges after accept.
- Full carry chain: A=0xFFFF_FFFF_FFFF_FFFF, B=0, cin=1 → `rsp_sum`=0, `rsp_cout`=1.
- Arbitration: both requesters hold valid continuously with `rsp_ready`=1 → grants alternate 0,1,0,1; `rsp_id` matches each grant; period 6 cycles.
- Backpressure: `rsp_ready`=0 for 5 cycles in RESP → outputs stable, `req_ready`=0, no accept; the handshake on cycle 6 returns the block to IDLE.
- Reset mid-ADD: assert `rst` during the second ADD cycle → the next cycle shows all outputs 0 and `busy`=0, no response is ever emitted, and requester 0 wins the next arbitration.
- With `BK_SEQ_SUB_EN`: A=5, B=7, sub=1 → `rsp_sum`=0xFFFF_FFFF_FFFF_FFFE, `rsp_cout`=0; then A=7, B=5 → `rsp_sum`=2, `rsp_cout`=1.
